wb_core_mem_arbiter: RTL and testbench

- Parametrised successor to the single-core memory controller top.
- Owns one synchronous word-addressed data memory shared by two requesters:
  - a Wishbone B4 classic slave, for external/debug access;
  - a RISC-V core data port, using req/ready.
- Replaces static port selection with a cycle-level round-robin arbiter.
- Adds byte enables, configurable Wishbone wait states, and error termination for out-of-range addresses.

---
 rtl/wb_core_mem_arbiter_if.sv | 38 +++
 rtl/wb_core_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_core_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_core_mem_arbiter_if.sv
// Bus bundle for wb_core_mem_arbiter: Wishbone B4 classic slave signals plus
// the core data port (req/ready). The arbiter takes the slave modport; the
// requesters (or a bench) drive through the master modport.
interface wb_core_mem_arbiter_if #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32
) ();
  // Wishbone side
  logic [ADDRESS_LENGTH-1:0]  ADR_I;
  logic [DATA_LENGTH-1:0]     DAT_I;
  logic [DATA_LENGTH/8-1:0]   SEL_I;
  logic                       we;
  logic                       stb;
  logic                       cyc;
  logic [DATA_LENGTH-1:0]     DAT_O;
  logic                       ack;
  logic                       err;
  // core side
  logic                       core_req;
  logic                       core_we;
  logic [ADDRESS_LENGTH-1:0]  core_addr;
  logic [DATA_LENGTH-1:0]     core_wdata;
  logic [DATA_LENGTH/8-1:0]   core_be;
  logic [DATA_LENGTH-1:0]     core_rdata;
  logic                       core_ready;

  modport slave (
    input  ADR_I, DAT_I, SEL_I, we, stb, cyc,
    input  core_req, core_we, core_addr, core_wdata, core_be,
    output DAT_O, ack, err, core_rdata, core_ready
  );

  modport master (
    output ADR_I, DAT_I, SEL_I, we, stb, cyc,
    output core_req, core_we, core_addr, core_wdata, core_be,
    input  DAT_O, ack, err, core_rdata, core_ready
  );
endinterface

// File: rtl/wb_core_mem_arbiter.sv
// wb_core_mem_arbiter: one synchronous word-addressed data memory shared by a
// Wishbone classic slave port and a core req/ready port, with cycle-level
// round-robin arbitration, byte enables, programmable Wishbone wait states and
// error termination for out-of-range addresses.
// Optional macro MEM_ARB_PERF_CNT_EN adds saturating 32-bit performance
// counters (perf_core_cnt, perf_wb_cnt, perf_conflict_cnt).
module wb_core_mem_arbiter #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int WAIT_STATES    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_core_mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_core_cnt,
  output logic [31:0]           perf_wb_cnt,
  output logic [31:0]           perf_conflict_cnt
`endif
);

  localparam int NB    = DATA_LENGTH / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, CORE_ACC, WB_WAIT, WB_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    lg_wb_q, lg_wb_d;   // 1: last grant went to Wishbone
  logic                    ack_q, err_q, core_ready_q;
  logic [DATA_LENGTH-1:0]  dat_o_q, core_rdata_q;

  logic [DATA_LENGTH-1:0]  mem [DEPTH_WORDS];

  logic                    wb_req, wb_live, wb_enter_resp;
  logic [ADDRESS_LENGTH-1:0] acc_addr;
  logic [IDX_W-1:0]        idx;
  logic                    oor;
  logic                    wr_en;
  logic [NB-1:0]           wr_be;
  logic [DATA_LENGTH-1:0]  wr_data;
  logic                    unused_addr_bits;

  // Only one port owns the memory at a time, so a single address mux serves
  // both the read port and the write port.
  assign acc_addr         = (state_q == CORE_ACC) ? bus.core_addr : bus.ADR_I;
  assign idx              = acc_addr[IDX_W+1:2];
  assign oor              = |acc_addr[ADDRESS_LENGTH-1:IDX_W+2];
  assign unused_addr_bits = ^acc_addr[1:0];

  assign wb_live       = bus.cyc & bus.stb;
  assign wb_req        = wb_live & ~ack_q & ~err_q;
  assign wb_enter_resp = (state_q == WB_WAIT) && (state_d == WB_RESP);

  // Next-state logic: round-robin grant in IDLE, wait-state countdown, abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lg_wb_d = lg_wb_q;
    case (state_q)
      IDLE: begin
        if (bus.core_req && (!wb_req || lg_wb_q)) begin
          state_d = CORE_ACC;
          lg_wb_d = 1'b0;
        end else if (wb_req) begin
          state_d = WB_WAIT;
          cnt_d   = 4'(WAIT_STATES);
          lg_wb_d = 1'b1;
        end
      end
      CORE_ACC: state_d = IDLE;
      WB_WAIT: begin
        if (!wb_live)           state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = WB_RESP;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      WB_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port select: core writes at the end of CORE_ACC, Wishbone writes at
  // the end of WB_RESP (ack_q already encodes the in-range check).
  always_comb begin
    wr_en   = 1'b0;
    wr_be   = '0;
    wr_data = bus.core_wdata;
    if (state_q == CORE_ACC) begin
      wr_en = bus.core_we & ~oor;
      wr_be = bus.core_be;
    end else if (state_q == WB_RESP) begin
      wr_en   = ack_q & bus.we;
      wr_be   = bus.SEL_I;
      wr_data = bus.DAT_I;
    end
  end

  // FSM state, wait counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lg_wb_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lg_wb_q <= lg_wb_d;
    end
  end

  // Memory array: byte-masked writes; reset on the same edge cancels a write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered responses: ack/err and DAT_O are set on entry to WB_RESP so
  // they are valid during that cycle; core_ready follows CORE_ACC.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      core_ready_q <= 1'b0;
      dat_o_q      <= '0;
      core_rdata_q <= '0;
    end else begin
      ack_q        <= wb_enter_resp & ~oor;
      err_q        <= wb_enter_resp & oor;
      core_ready_q <= (state_q == CORE_ACC);
      if (wb_enter_resp) dat_o_q <= oor ? '0 : mem[idx];
      if ((state_q == CORE_ACC) && (oor || !bus.core_we))
        core_rdata_q <= oor ? '0 : mem[idx];
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.DAT_O      = dat_o_q;
  assign bus.core_ready = core_ready_q;
  assign bus.core_rdata = core_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pc_core_q, pc_wb_q, pc_conf_q;

  // Saturating event counters: core completions, WB ack/err, IDLE conflicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_core_q <= '0;
      pc_wb_q   <= '0;
      pc_conf_q <= '0;
    end else begin
      if ((state_q == CORE_ACC) && (pc_core_q != '1)) pc_core_q <= pc_core_q + 32'd1;
      if (wb_enter_resp && (pc_wb_q != '1))           pc_wb_q   <= pc_wb_q + 32'd1;
      if ((state_q == IDLE) && bus.core_req && wb_req && (pc_conf_q != '1))
        pc_conf_q <= pc_conf_q + 32'd1;
    end
  end

  assign perf_core_cnt     = pc_core_q;
  assign perf_wb_cnt       = pc_wb_q;
  assign perf_conflict_cnt = pc_conf_q;
`endif

endmodule

// File: tb/tb_wb_core_mem_arbiter.sv
// Bench for wb_core_mem_arbiter: directed scenarios with literal expectations
// plus two random agents (core, Wishbone) checked every cycle against a
// transaction-timestamp model of the shared memory and its arbiter.
module tb_wb_core_mem_arbiter;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_core_mem_arbiter_if #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) bus  ();
  wb_core_mem_arbiter_if #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) bus3 ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pc_core, pc_wb, pc_conf, p3_core, p3_wb, p3_conf;
`endif

  wb_core_mem_arbiter #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(rst), .bus(bus)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_core_cnt(pc_core), .perf_wb_cnt(pc_wb), .perf_conflict_cnt(pc_conf)
`endif
  );

  wb_core_mem_arbiter #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst), .bus(bus3)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_core_cnt(p3_core), .perf_wb_cnt(p3_wb), .perf_conflict_cnt(p3_conf)
`endif
  );

  int vecs = 0, miscmp = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%08h, want 0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    vecs++;
    miscmp++;
    $display("FAIL %s: timed out waiting for DUT @%0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  // Timestamped view: a grant in cycle k makes the core answer in k+2 and
  // Wishbone answer in k+WS+2; the arbiter is free again at k+2 / k+WS+3.
  bit [31:0] mm [int];
  int  cur = 0, m_free = 0, m_core_at = -1, m_wb_at = -1;
  bit  m_lg_wb = 1'b1;
  bit  m_cpend, m_cwe, m_wpend, m_wwe, m_werr;
  bit [31:0] m_caddr, m_cwd, m_crd, m_waddr, m_wwd, m_wdo;
  bit [3:0]  m_cbe, m_wsel;

  function automatic bit oor_f(input bit [31:0] a);
    return a[31:12] != 20'h0;
  endfunction

  function automatic int idx_f(input bit [31:0] a);
    return int'(a[11:2]);
  endfunction

  function bit [31:0] rd_m(input int i);
    return mm.exists(i) ? mm[i] : 32'h0;
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
    bit [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_free = cur + 1; m_core_at = -1; m_wb_at = -1;
        m_lg_wb = 1'b1; m_cpend = 1'b0; m_wpend = 1'b0;
      end else begin
        if (m_cpend && cur == m_core_at - 1) begin
          m_cpend = 1'b0;
          if (oor_f(m_caddr)) m_crd = 32'h0;
          else if (m_cwe)     mm[idx_f(m_caddr)] = merge(rd_m(idx_f(m_caddr)), m_cwd, m_cbe);
          else                m_crd = rd_m(idx_f(m_caddr));
        end
        if (m_wpend && cur == m_wb_at) begin
          m_wpend = 1'b0;
          mm[idx_f(m_waddr)] = merge(rd_m(idx_f(m_waddr)), m_wwd, m_wsel);
        end
        if (cur >= m_free) begin
          if (bus.core_req && (!(bus.cyc && bus.stb) || m_lg_wb)) begin
            m_cpend = 1'b1; m_cwe = bus.core_we; m_caddr = bus.core_addr;
            m_cwd = bus.core_wdata; m_cbe = bus.core_be;
            m_core_at = cur + 2; m_free = cur + 2; m_lg_wb = 1'b0;
          end else if (bus.cyc && bus.stb) begin
            m_waddr = bus.ADR_I; m_wwd = bus.DAT_I; m_wsel = bus.SEL_I; m_wwe = bus.we;
            m_werr  = oor_f(bus.ADR_I);
            m_wdo   = m_werr ? 32'h0 : rd_m(idx_f(bus.ADR_I));
            m_wpend = bus.we && !m_werr;
            m_wb_at = cur + WS + 2; m_free = cur + WS + 3; m_lg_wb = 1'b1;
          end
        end
      end
      cur++;
    end
  end

  // Per-cycle comparison of the main DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("core_ready", {31'h0, bus.core_ready}, {31'h0, cur == m_core_at});
        chk("ack", {31'h0, bus.ack}, {31'h0, (cur == m_wb_at) && !m_werr});
        chk("err", {31'h0, bus.err}, {31'h0, (cur == m_wb_at) && m_werr});
        if (cur == m_core_at && !m_cwe) chk("core_rdata", bus.core_rdata, m_crd);
        if (cur == m_wb_at && (m_werr || !m_wwe)) chk("DAT_O", bus.DAT_O, m_wdo);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+#1) ----------------
  task automatic core_op(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] be,
                         output bit [31:0] rd, output int lat);
    bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = wd; bus.core_be = be;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.core_ready && lat < 100);
    if (!bus.core_ready) timeout("core_op");
    rd = bus.core_rdata;
    bus.core_req = 1'b0;
  endtask

  task automatic wb_op(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] sel,
                       output bit [31:0] dato, output bit ak, output bit er, output int lat);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.ADR_I = a; bus.DAT_I = wd; bus.SEL_I = sel;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!(bus.ack || bus.err) && lat < 100);
    if (!(bus.ack || bus.err)) timeout("wb_op");
    dato = bus.DAT_O; ak = bus.ack; er = bus.err;
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0;
  endtask

  function automatic bit [31:0] pick_addr();
    int r = $urandom_range(0, 19);
    if (r >= 15) return 32'h1000 + ($urandom_range(0, 1023) << 2) + (r == 19 ? 32'hFFFF_E000 : 32'h0);
    return 32'h100 + r * 4 + $urandom_range(0, 3);
  endfunction

  task automatic core_agent(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      int idle = $urandom_range(0, 3);
      if (idle > 0) begin
        bus.core_req = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
      end
      bus.core_req = 1'b1; bus.core_we = 1'($urandom_range(0, 1)); bus.core_addr = pick_addr();
      bus.core_wdata = $urandom; bus.core_be = 4'($urandom_range(0, 15));
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!bus.core_ready && t < 100);
      if (!bus.core_ready) timeout("core_agent");
    end
    bus.core_req = 1'b0;
  endtask

  task automatic wb_agent(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      int idle = $urandom_range(0, 3);
      repeat (idle) begin @(posedge clk); #1; end
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'($urandom_range(0, 1)); bus.ADR_I = pick_addr();
      bus.DAT_I = $urandom; bus.SEL_I = 4'($urandom_range(0, 15));
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!(bus.ack || bus.err) && t < 100);
      if (!(bus.ack || bus.err)) timeout("wb_agent");
      @(posedge clk); #1;
      bus.cyc = 1'b0; bus.stb = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    bit [31:0] rd, dato;
    bit ak, er;
    int lat, t, nc, nw, acks;
    int cr[4], wa[4];

    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0; bus.core_be = 0;
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.ADR_I = 0; bus.DAT_I = 0; bus.SEL_I = 0;
    bus3.core_req = 0; bus3.core_we = 0; bus3.core_addr = 0; bus3.core_wdata = 0; bus3.core_be = 0;
    bus3.cyc = 0; bus3.stb = 0; bus3.we = 0; bus3.ADR_I = 0; bus3.DAT_I = 0; bus3.SEL_I = 0;
    rst = 1'b1;
    @(posedge clk); chk_en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // reset values
    chk("rst_ack", {31'h0, bus.ack}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_core_ready", {31'h0, bus.core_ready}, 32'h0);
    chk("rst_DAT_O", bus.DAT_O, 32'h0);
    chk("rst_core_rdata", bus.core_rdata, 32'h0);
    rst = 1'b0;

    // core write then read
    core_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("core_wr_latency", 32'(lat), 32'd2);
    core_op(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    chk("core_rd_latency", 32'(lat), 32'd2);
    chk("core_rd_data", rd, 32'hDEADBEEF);

    // WB byte-select write over all-ones
    wb_op(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, dato, ak, er, lat);
    wb_op(1'b1, 32'h20, 32'h12345678, 4'h3, dato, ak, er, lat);
    chk("wb_ack_latency", 32'(lat), 32'd3);
    chk("wb_wr_ack", {31'h0, ak}, 32'h1);
    wb_op(1'b0, 32'h20, 32'h0, 4'hF, dato, ak, er, lat);
    chk("wb_sel_merge", dato, 32'hFFFF5678);

    // out-of-range WB accesses
    wb_op(1'b0, 32'h1000, 32'h0, 4'hF, dato, ak, er, lat);
    chk("oor_err", {31'h0, er}, 32'h1);
    chk("oor_ack", {31'h0, ak}, 32'h0);
    chk("oor_DAT_O", dato, 32'h0);
    chk("oor_err_one_cycle", {31'h0, bus.err}, 32'h0);
    wb_op(1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, dato, ak, er, lat);
    chk("oor_wr_err", {31'h0, er}, 32'h1);
    core_op(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    chk("oor_wr_no_alias", rd, 32'hDEADBEEF);

    // both ports from reset, held: core, WB, core, WB
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h10; bus.core_be = 4'hF;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.ADR_I = 32'h20; bus.SEL_I = 4'hF;
    nc = 0; nw = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (bus.core_ready && nc < 4) begin cr[nc] = n; nc++; end
      if (bus.ack && nw < 4) begin wa[nw] = n; nw++; end
    end
    bus.core_req = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
    chk("alt_core_count", 32'(nc), 32'd2);
    chk("alt_wb_count", 32'(nw), 32'd2);
    if (nc == 2 && nw == 2) begin
      chk("alt_core1", 32'(cr[0]), 32'd2);
      chk("alt_wb1",   32'(wa[0]), 32'd5);
      chk("alt_core2", 32'(cr[1]), 32'd8);
      chk("alt_wb2",   32'(wa[1]), 32'd11);
    end
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_conflict_nonzero", {31'h0, pc_conf >= 32'd1}, 32'h1);
`endif

    // reset during WB_RESP of a write
    core_op(1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, lat);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.ADR_I = 32'h40; bus.DAT_I = 32'h55555555; bus.SEL_I = 4'hF;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus.ack && t < 100);
    if (!bus.ack) timeout("reset_resp_ack");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
    chk("rst_resp_ack_low", {31'h0, bus.ack}, 32'h0);
    core_op(1'b0, 32'h40, 32'h0, 4'hF, rd, lat);
    chk("rst_resp_idle_latency", 32'(lat), 32'd2);
    chk("rst_resp_no_write", rd, 32'h0BADF00D);

    // WB abort during WB_WAIT on the WAIT_STATES=3 instance
    bus3.core_req = 1'b1; bus3.core_we = 1'b1; bus3.core_addr = 32'h30; bus3.core_wdata = 32'hAAAA5555; bus3.core_be = 4'hF;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus3.core_ready && t < 100);
    if (!bus3.core_ready) timeout("abort_prewrite");
    bus3.core_req = 1'b0;
    bus3.cyc = 1'b1; bus3.stb = 1'b1; bus3.we = 1'b1; bus3.ADR_I = 32'h30; bus3.DAT_I = 32'h11112222; bus3.SEL_I = 4'hF;
    acks = 0;
    repeat (2) begin @(posedge clk); #1; if (bus3.ack || bus3.err) acks++; end
    bus3.cyc = 1'b0; bus3.stb = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (bus3.ack || bus3.err) acks++; end
    chk("abort_no_ack", 32'(acks), 32'd0);
    bus3.core_req = 1'b1; bus3.core_we = 1'b0; bus3.core_addr = 32'h30;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus3.core_ready && t < 100);
    if (!bus3.core_ready) timeout("abort_readback");
    chk("abort_ws3_rd_latency", 32'(t), 32'd2);
    chk("abort_no_write", bus3.core_rdata, 32'hAAAA5555);
    bus3.core_req = 1'b0;

    // random phase: initialise the address pool, then run both agents
    for (int r = 0; r < 15; r++) core_op(1'b1, 32'h100 + r * 4, $urandom, 4'hF, rd, lat);
    fork
      core_agent(200);
      wb_agent(200);
    join
    repeat (6) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
